// File: rtl/cpu_pkg.sv
// Shared CPU-side constants: loader state encoding, bus widths, frame field masks.
// Pure definitions; no logic, no latency, no flow control.
package cpu_pkg;

  localparam int ADDR_W  = 16;
  localparam int INSTR_W = 18;
  localparam int LEN_W   = 16;

  typedef enum logic [2:0] {
    S_LENHI = 3'd0,
    S_LENLO = 3'd1,
    S_B0    = 3'd2,
    S_B1    = 3'd3,
    S_B2    = 3'd4,
    S_CSUM  = 3'd5,
    S_DONE  = 3'd6,
    S_ERROR = 3'd7
  } loadState_t;

  // B0 bits [0:5] are padding above the 2-bit instruction prefix and must be zero.
  localparam logic [0:7] B0_PAD_MASK = 8'hFC;

endpackage

// File: rtl/incrementer.sv
// Combinational +1/-1 stepper (i_dir=1 counts up, 0 counts down), wrapping modulo 2^W.
// Zero latency; no flow control.
module incrementer #(
  parameter int W = 16
) (
  input  logic [0:W-1] i_value,
  input  logic         i_dir,
  output logic [0:W-1] o_value
);

  localparam logic [0:W-1] ONE = W'(1);

  assign o_value = i_dir ? (i_value + ONE) : (i_value - ONE);

endmodule

// File: rtl/progloader.sv
// Byte-serial framed image loader into program RAM; holds the CPU until the checksum verifies.
// Write strobe registered one cycle after B2; accepts a byte every cycle while receiving, stalls in DONE/ERROR.
module progloader #(
  parameter int ADDR_W  = cpu_pkg::ADDR_W,
  parameter int INSTR_W = cpu_pkg::INSTR_W
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_rxValid,
  input  logic [0:7]          i_rxByte,
  output logic                o_rxReady,
  input  logic                i_start,
  output logic                o_memWrite,
  output logic [0:ADDR_W-1]   o_memAddr,
  output logic [0:INSTR_W-1]  o_memData,
  output logic                o_cpuHold,
  output logic                o_done,
  output logic                o_error
);

  import cpu_pkg::*;

  loadState_t state, stateNext;

  logic             accept;
  logic             rearm;
  logic [0:7]       lenHi;
  logic [0:1]       b0Low;
  logic [0:7]       b1Byte;
  logic [0:7]       xorAcc;
  logic [0:LEN_W-1] lenWord;
  logic [0:ADDR_W-1] addrCnt, addrNext;
  logic [0:LEN_W-1] wordsLeft, wordsNext;

  assign accept  = i_rxValid & o_rxReady;
  assign rearm   = i_start & ((state == S_DONE) | (state == S_ERROR));
  assign lenWord = {lenHi, i_rxByte};

  incrementer #(.W(ADDR_W)) addrStep (
    .i_value (addrCnt),
    .i_dir   (1'b1),
    .o_value (addrNext)
  );

  incrementer #(.W(LEN_W)) wordStep (
    .i_value (wordsLeft),
    .i_dir   (1'b0),
    .o_value (wordsNext)
  );

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) state <= S_LENHI;
    else         state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      S_LENHI: if (accept) stateNext = S_LENLO;
      S_LENLO: if (accept) stateNext = (lenWord != '0) ? S_B0 : S_CSUM;
      S_B0:    if (accept) stateNext = ((i_rxByte & B0_PAD_MASK) != 8'h00) ? S_ERROR : S_B1;
      S_B1:    if (accept) stateNext = S_B2;
      S_B2:    if (accept) stateNext = (wordsLeft > LEN_W'(1)) ? S_B0 : S_CSUM;
      S_CSUM:  if (accept) stateNext = ((xorAcc ^ i_rxByte) == 8'h00) ? S_DONE : S_ERROR;
      S_DONE, S_ERROR: if (i_start) stateNext = S_LENHI;
      default: stateNext = S_LENHI;
    endcase
  end

  always_comb begin
    o_rxReady = 1'b1;
    o_cpuHold = 1'b1;
    o_done    = 1'b0;
    o_error   = 1'b0;
    case (state)
      S_DONE: begin
        o_rxReady = 1'b0;
        o_cpuHold = 1'b0;
        o_done    = 1'b1;
      end
      S_ERROR: begin
        o_rxReady = 1'b0;
        o_error   = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath: byte capture, checksum, counters and the registered write port.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      lenHi      <= '0;
      b0Low      <= '0;
      b1Byte     <= '0;
      xorAcc     <= '0;
      addrCnt    <= '0;
      wordsLeft  <= '0;
      o_memWrite <= 1'b0;
      o_memAddr  <= '0;
      o_memData  <= '0;
    end else begin
      o_memWrite <= 1'b0;
      if (accept) begin
        xorAcc <= xorAcc ^ i_rxByte;
        case (state)
          S_LENHI: lenHi     <= i_rxByte;
          S_LENLO: wordsLeft <= lenWord;
          S_B0:    b0Low     <= i_rxByte[6:7];
          S_B1:    b1Byte    <= i_rxByte;
          S_B2: begin
            o_memWrite <= 1'b1;
            o_memAddr  <= addrCnt;
            o_memData  <= {b0Low, b1Byte, i_rxByte};
            addrCnt    <= addrNext;
            wordsLeft  <= wordsNext;
          end
          default: ;
        endcase
      end
      if (rearm) begin
        xorAcc  <= '0;
        addrCnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_progloader.sv
// Directed bench for progloader: byte streams driven at full rate, expected writes queued
// as stimulus is built and popped whenever the write strobe is seen.
module tb_progloader;

  localparam int ADDR_W  = 16;
  localparam int INSTR_W = 18;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                rxValid = 1'b0;
  logic [0:7]          rxByte = 8'h00;
  logic                rxReady;
  logic                start = 1'b0;
  logic                memWrite;
  logic [0:ADDR_W-1]   memAddr;
  logic [0:INSTR_W-1]  memData;
  logic                cpuHold;
  logic                done;
  logic                error;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t        expQ[$];
  logic [7:0] stim[$];
  int         checks = 0;
  int         errors = 0;
  int         extraWrites = 0;

  progloader #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) dut (
    .i_clock    (clk),
    .i_reset    (rst),
    .i_rxValid  (rxValid),
    .i_rxByte   (rxByte),
    .o_rxReady  (rxReady),
    .i_start    (start),
    .o_memWrite (memWrite),
    .o_memAddr  (memAddr),
    .o_memData  (memData),
    .o_cpuHold  (cpuHold),
    .o_done     (done),
    .o_error    (error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; outputs sampled 1 time unit after the edge, write strobes checked against the queue.
  task automatic tick();
    wr_t e;
    @(posedge clk);
    #1;
    if (memWrite === 1'b1) begin
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        check("wr_addr", 32'(memAddr), e.addr);
        check("wr_data", 32'(memData), e.data);
      end else begin
        extraWrites++;
      end
    end
  endtask

  task automatic sendAll();
    foreach (stim[i]) begin
      rxValid = 1'b1;
      rxByte  = stim[i];
      tick();
    end
    rxValid = 1'b0;
    rxByte  = 8'h00;
  endtask

  task automatic pushWr(input logic [31:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    expQ.push_back(e);
  endtask

  task automatic endScenario(input string tag);
    tick();
    check({tag, "_pending"}, 32'(expQ.size()), 32'd0);
    check({tag, "_extra"}, 32'(extraWrites), 32'd0);
    expQ.delete();
    extraWrites = 0;
  endtask

  task automatic pulseStart();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("rearm_hold", 32'(cpuHold), 32'd1);
    check("rearm_done", 32'(done), 32'd0);
    check("rearm_ready", 32'(rxReady), 32'd1);
  endtask

  initial begin
    #12;
    check("rst_ready", 32'(rxReady), 32'd1);
    check("rst_write", 32'(memWrite), 32'd0);
    check("rst_addr", 32'(memAddr), 32'd0);
    check("rst_data", 32'(memData), 32'd0);
    check("rst_hold", 32'(cpuHold), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    rst = 1'b0;

    // Good two-word image.
    pushWr(32'h0, 32'h12345);
    pushWr(32'h1, 32'h2ABCD);
    stim = '{8'h00, 8'h02, 8'h01, 8'h23, 8'h45, 8'h02, 8'hAB, 8'hCD, 8'h01};
    sendAll();
    check("ok_done", 32'(done), 32'd1);
    check("ok_hold", 32'(cpuHold), 32'd0);
    check("ok_ready", 32'(rxReady), 32'd0);
    check("ok_error", 32'(error), 32'd0);
    endScenario("ok");

    // Same image with a bad checksum: writes still happen, then ERROR.
    pulseStart();
    pushWr(32'h0, 32'h12345);
    pushWr(32'h1, 32'h2ABCD);
    stim = '{8'h00, 8'h02, 8'h01, 8'h23, 8'h45, 8'h02, 8'hAB, 8'hCD, 8'h00};
    sendAll();
    check("csum_error", 32'(error), 32'd1);
    check("csum_hold", 32'(cpuHold), 32'd1);
    check("csum_ready", 32'(rxReady), 32'd0);
    check("csum_done", 32'(done), 32'd0);
    stim = '{8'h55, 8'h00};
    sendAll();
    check("csum_dropped_error", 32'(error), 32'd1);
    endScenario("csum");

    // Non-zero pad bits in B0.
    pulseStart();
    stim = '{8'h00, 8'h01, 8'h41};
    sendAll();
    check("pad_error", 32'(error), 32'd1);
    check("pad_ready", 32'(rxReady), 32'd0);
    stim = '{8'h00, 8'h00};
    sendAll();
    check("pad_still_error", 32'(error), 32'd1);
    endScenario("pad");

    // Empty image.
    pulseStart();
    stim = '{8'h00, 8'h00, 8'h00};
    sendAll();
    check("empty_done", 32'(done), 32'd1);
    check("empty_hold", 32'(cpuHold), 32'd0);
    endScenario("empty");

    // Reset mid-frame after B1 of word 1, with start asserted alongside it.
    pulseStart();
    stim = '{8'h00, 8'h02, 8'h01, 8'h23};
    sendAll();
    rst   = 1'b1;
    start = 1'b1;
    #2;
    check("midrst_ready", 32'(rxReady), 32'd1);
    check("midrst_hold", 32'(cpuHold), 32'd1);
    check("midrst_done", 32'(done), 32'd0);
    tick();
    check("midrst_write", 32'(memWrite), 32'd0);
    check("midrst_addr", 32'(memAddr), 32'd0);
    rst   = 1'b0;
    start = 1'b0;
    pushWr(32'h0, 32'h12345);
    pushWr(32'h1, 32'h2ABCD);
    stim = '{8'h00, 8'h02, 8'h01, 8'h23, 8'h45, 8'h02, 8'hAB, 8'hCD, 8'h01};
    sendAll();
    check("midrst_final_done", 32'(done), 32'd1);
    endScenario("midrst");

    // Re-arm from DONE and load a single word.
    pulseStart();
    pushWr(32'h0, 32'h00007);
    stim = '{8'h00, 8'h01, 8'h00, 8'h00, 8'h07, 8'h06};
    sendAll();
    check("reload_done", 32'(done), 32'd1);
    check("reload_hold", 32'(cpuHold), 32'd0);
    endScenario("reload");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/progloader.md
# progloader

Byte-serial program loader sitting directly upstream of `cpu`. It accepts a framed byte stream from the UART receiver, assembles 18-bit instruction words, writes them sequentially into program memory (the RAM backing `programrom`) from address 0, and holds the CPU in reset until a checksum-verified image is resident. On a bad frame it latches an error and keeps the CPU held.

## Interface
Parameters:
- `ADDR_W`, 16, program-memory address width (matches the IP width).
- `INSTR_W`, 18, instruction width; must be 18 (2 + 8 + 8 bits).

Ports (bit 0 is the MSB throughout, `[0:N]` ordering):
- `i_clock`  in  1  system clock; all state changes on the rising edge.
- `i_reset`  in  1  asynchronous, active-high reset.
- `i_rxValid`  in  1  `i_rxByte` holds a valid byte.
- `i_rxByte`  in  8  received byte `[0:7]`.
- `o_rxReady`  out  1  loader can accept a byte. A byte transfers when `i_rxValid & o_rxReady` at a clock edge.
- `i_start`  in  1  single-cycle re-arm request; honoured only in DONE or ERROR.
- `o_memWrite`  out  1  program-memory write strobe, one cycle per word.
- `o_memAddr`  out  ADDR_W  write address.
- `o_memData`  out  INSTR_W  write data.
- `o_cpuHold`  out  1  drives the CPU reset/hold.
- `o_done`  out  1  image loaded and verified.
- `o_error`  out  1  framing or checksum error latched.

Reset values: `o_rxReady`=1, `o_memWrite`=0, `o_memAddr`=0, `o_memData`=0, `o_cpuHold`=1, `o_done`=0, `o_error`=0.

## Operation
- Frame format: `LEN_HI`, `LEN_LO` (16-bit word count N, big-endian), then N × {B0, B1, B2}, then `CSUM`.
- Instruction word = {B0[6:7], B1, B2}. B0[0:5] must be zero.
- Checksum: running XOR of every byte, length bytes included. The frame is valid when the XOR including `CSUM` equals 0x00.
- States:
  - S_LENHI → S_LENLO.
  - S_LENLO → S_B0 if N≠0, else S_CSUM.
  - S_B0 → S_B1, or S_ERROR if B0[0:5]≠0.
  - S_B1 → S_B2.
  - S_B2 → S_B0 if words remaining > 1, else S_CSUM.
  - S_CSUM → S_DONE if the final XOR is 0, else S_ERROR.
  - S_DONE and S_ERROR → S_LENHI on `i_start`.
- Transitions occur only on an accepted byte, except the exit from S_DONE or S_ERROR on `i_start`.
- Address counter clears on entry to S_LENHI and increments after each write. N ≤ 65535, so the last address is ≤ 0xFFFE and the counter never wraps.
- The remaining-word counter loads N at LEN_LO and decrements after each write.
- `o_rxReady` = 1 in S_LENHI through S_CSUM, and 0 in S_DONE and S_ERROR. Bytes offered while ready is 0 are dropped; `i_rxValid` has no effect there.
- `o_cpuHold` = 0 only in S_DONE. `o_done` = 1 only in S_DONE. `o_error` = 1 only in S_ERROR.
- Re-arm with `i_start`: clears the XOR accumulator, address counter and flags, and reasserts hold.
- A reset at any point, including mid-frame, aborts the load and returns to S_LENHI. Memory contents already written are not erased.

## Timing
- B2 accepted at edge k: `o_memWrite`=1 for the cycle after edge k, with registered `o_memAddr` and `o_memData`. `o_memWrite` deasserts at edge k+1.
- Back-to-back bytes at full rate are supported. The next B0 may be accepted during the write cycle, so `o_rxReady` never drops for a write.
- CSUM accepted at edge k: `o_done`=1 and `o_cpuHold`=0 from edge k onward (registered state outputs). The CPU therefore sees hold low on the cycle after the last byte.
- `i_start` in S_DONE at edge k: `o_cpuHold`=1, `o_done`=0 and `o_rxReady`=1 after edge k.
- `i_start` while in a receiving state is ignored.
- `i_start` asserted together with `i_reset` has no effect; reset dominates.

## Structure
- Shared package `cpu_pkg`:
  - state encoding constants;
  - `ADDR_W`, `INSTR_W`;
  - frame field positions (B0 pad mask `[0:5]`).
- Reuse the existing `incrementer`:
  - with `i_dir`=1 for the address counter;
  - with `i_dir`=0 for the remaining-word counter.
- Everything else (FSM, XOR accumulator, B0/B1 holding registers, output registers) lives in `progloader`.

## Test plan
- Stream 00 02 01 23 45 02 AB CD 01 at full rate → writes addr 0 = 0x12345 and addr 1 = 0x2ABCD, one `o_memWrite` cycle each; `o_done`=1 and `o_cpuHold`=0 the cycle after CSUM.
- Same stream with CSUM 0x00 → both writes still occur; `o_error`=1, `o_cpuHold` stays 1, `o_rxReady`=0.
- Stream 00 01 41 00 00 … → no write; S_ERROR immediately after B0, because B0[0:5]≠0.
- Stream 00 00 00 (N=0, CSUM 0x00) → no writes; `o_done`=1.
- Assert `i_reset` after the B1 of word 1 in the first stream, then send the full stream → exactly two writes to addrs 0 and 1; DONE.
- From DONE pulse `i_start` → `o_cpuHold`=1; send 00 01 00 00 07 06 → addr 0 = 0x00007; DONE again.
